// File: rtl/ucsbece154_icache_lru.sv
// ucsbece154_icache_lru
//
// Set-associative instruction cache between core fetch and the SDRAM controller.
// It uses true-LRU replacement, forwards the requested word as soon as its beat
// arrives during a refill, supports a whole-cache flush, and counts hits and misses
// in saturating counters.
//
// Ports
//   Clk, ResetN       clock (rising edge) and synchronous active-low reset
//   ReadEnable        fetch request, sampled in IDLE only
//   ReadAddress       word-aligned fetch byte address
//   Flush             invalidate every line (pulse or level)
//   Instruction       fetched word, valid while Ready=1, otherwise holds
//   Ready             one-cycle pulse per accepted fetch
//   Busy              miss service or a deferred flush is pending
//   MemReadAddress    line base address of the refill
//   MemReadRequest    refill request, held until the last beat is accepted
//   MemDataIn         refill beat data
//   MemDataReady      refill beat strobe
//   HitCount          accepted hits, saturating
//   MissCount         accepted misses, saturating
//
// Handshake: a fetch is accepted on a rising edge where the FSM is in IDLE,
// ReadEnable=1 and Flush=0. A hit answers with Ready one cycle later. A miss
// raises Busy one cycle later; the core holds ReadEnable/ReadAddress stable until
// Busy drops, and Ready pulses exactly once for that fetch (possibly while Busy is
// still 1). On the memory side, each edge with MemDataReady=1 consumes one beat;
// beats arrive in ascending word order starting at the line base.

module ucsbece154_icache_lru #(
    parameter int NUM_SETS    = 8,
    parameter int NUM_WAYS    = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int WORD_SIZE   = 32,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    input  logic                 ReadEnable,
    input  logic [31:0]          ReadAddress,
    input  logic                 Flush,
    output logic [WORD_SIZE-1:0] Instruction,
    output logic                 Ready,
    output logic                 Busy,
    output logic [31:0]          MemReadAddress,
    output logic                 MemReadRequest,
    input  logic [WORD_SIZE-1:0] MemDataIn,
    input  logic                 MemDataReady,
    output logic [CNT_WIDTH-1:0] HitCount,
    output logic [CNT_WIDTH-1:0] MissCount
);

    localparam int BB  = $clog2(BLOCK_WORDS);
    localparam int SB  = $clog2(NUM_SETS);
    localparam int WB  = $clog2(NUM_WAYS);
    localparam int OFF = 2 + BB;
    localparam int TB  = 32 - OFF - SB;

    // FLUSH is the extra cycle after a refill that had a flush request latched.
    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;
    state_t state;

    // Cache storage
    logic                 valid_q [NUM_SETS][NUM_WAYS];
    logic [WB-1:0]        age_q   [NUM_SETS][NUM_WAYS];
    logic [TB-1:0]        tag_q   [NUM_SETS][NUM_WAYS];
    logic [WORD_SIZE-1:0] data_q  [NUM_SETS][NUM_WAYS][BLOCK_WORDS];

    // Refill context latched at the miss
    logic [SB-1:0] fill_set;
    logic [TB-1:0] fill_tag;
    logic [BB-1:0] fill_off;
    logic [WB-1:0] fill_way;
    logic [BB-1:0] beat;
    logic          flush_pend;

    // Address split
    logic [BB-1:0] addr_off;
    logic [SB-1:0] addr_set;
    logic [TB-1:0] addr_tag;
    logic          unused_addr_bits;

    assign addr_off         = ReadAddress[OFF-1:2];
    assign addr_set         = ReadAddress[OFF+SB-1:OFF];
    assign addr_tag         = ReadAddress[31:OFF+SB];
    assign unused_addr_bits = ^ReadAddress[1:0];

    logic          last_beat;
    assign last_beat = MemDataReady && (beat == BB'(BLOCK_WORDS - 1));

    // Lookup and victim selection; lowest index wins among equals.
    logic          hit;
    logic [WB-1:0] hit_way;
    logic          any_inv;
    logic [WB-1:0] inv_way;
    logic [WB-1:0] lru_way;
    logic [WB-1:0] victim;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[addr_set][w] && (tag_q[addr_set][w] == addr_tag)) begin
                hit     = 1'b1;
                hit_way = WB'(w);
            end
            if (!valid_q[addr_set][w]) begin
                any_inv = 1'b1;
                inv_way = WB'(w);
            end
            if (age_q[addr_set][w] == WB'(NUM_WAYS - 1))
                lru_way = WB'(w);
        end
        victim = any_inv ? inv_way : lru_way;
    end

    // LRU touch: the touched way becomes age 0, every younger way ages by one.
    // Only the refill (FILL) or a hit (IDLE) ever applies this row.
    logic [SB-1:0] touch_set;
    logic [WB-1:0] touch_way;
    logic [WB-1:0] touch_age;
    logic [WB-1:0] new_age [NUM_WAYS];

    always_comb begin
        touch_set = (state == FILL) ? fill_set : addr_set;
        touch_way = (state == FILL) ? fill_way : hit_way;
        touch_age = age_q[touch_set][touch_way];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (WB'(w) == touch_way)
                new_age[w] = '0;
            else if (age_q[touch_set][w] < touch_age)
                new_age[w] = age_q[touch_set][w] + 1'b1;
            else
                new_age[w] = age_q[touch_set][w];
        end
    end

    // Control, valid bits, ages and outputs
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state          <= IDLE;
            Instruction    <= '0;
            Ready          <= 1'b0;
            Busy           <= 1'b0;
            MemReadAddress <= '0;
            MemReadRequest <= 1'b0;
            HitCount       <= '0;
            MissCount      <= '0;
            fill_set       <= '0;
            fill_tag       <= '0;
            fill_off       <= '0;
            fill_way       <= '0;
            beat           <= '0;
            flush_pend     <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= WB'(w);
                end
            end
        end else begin
            Ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (Flush) begin
                        for (int s = 0; s < NUM_SETS; s++) begin
                            for (int w = 0; w < NUM_WAYS; w++) begin
                                valid_q[s][w] <= 1'b0;
                                age_q[s][w]   <= WB'(w);
                            end
                        end
                    end else if (ReadEnable) begin
                        if (hit) begin
                            Instruction <= data_q[addr_set][hit_way][addr_off];
                            Ready       <= 1'b1;
                            for (int w = 0; w < NUM_WAYS; w++)
                                age_q[addr_set][w] <= new_age[w];
                            if (HitCount != {CNT_WIDTH{1'b1}})
                                HitCount <= HitCount + 1'b1;
                        end else begin
                            Busy           <= 1'b1;
                            MemReadRequest <= 1'b1;
                            MemReadAddress <= {ReadAddress[31:OFF], {OFF{1'b0}}};
                            if (MissCount != {CNT_WIDTH{1'b1}})
                                MissCount <= MissCount + 1'b1;
                            fill_set   <= addr_set;
                            fill_tag   <= addr_tag;
                            fill_off   <= addr_off;
                            fill_way   <= victim;
                            beat       <= '0;
                            flush_pend <= 1'b0;
                            state      <= FILL;
                        end
                    end
                end

                FILL: begin
                    if (Flush)
                        flush_pend <= 1'b1;
                    if (MemDataReady) begin
                        beat <= beat + 1'b1;
                        // Early restart: forward the requested word as it streams in.
                        if (beat == fill_off) begin
                            Instruction <= MemDataIn;
                            Ready       <= 1'b1;
                        end
                        if (last_beat) begin
                            valid_q[fill_set][fill_way] <= 1'b1;
                            for (int w = 0; w < NUM_WAYS; w++)
                                age_q[fill_set][w] <= new_age[w];
                            MemReadRequest <= 1'b0;
                            if (flush_pend || Flush) begin
                                state <= FLUSH;
                            end else begin
                                Busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            // Partially written line must never hit.
                            valid_q[fill_set][fill_way] <= 1'b0;
                        end
                    end
                end

                FLUSH: begin
                    for (int s = 0; s < NUM_SETS; s++) begin
                        for (int w = 0; w < NUM_WAYS; w++) begin
                            valid_q[s][w] <= 1'b0;
                            age_q[s][w]   <= WB'(w);
                        end
                    end
                    flush_pend <= 1'b0;
                    Busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Line storage: data beats and tag. No reset needed; valid bits gate use.
    always_ff @(posedge Clk) begin
        if (ResetN && (state == FILL) && MemDataReady) begin
            data_q[fill_set][fill_way][beat] <= MemDataIn;
            if (last_beat)
                tag_q[fill_set][fill_way] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_ucsbece154_icache_lru.sv
// tb_ucsbece154_icache_lru
//
// Bench for ucsbece154_icache_lru. Memory content is a fixed function of the
// word address, so every fetched word is known ahead of time and queued when the
// fetch is driven; a monitor pops and compares on each Ready pulse. A second
// instance with 2-bit counters shares all inputs for the saturation check.

module tb_ucsbece154_icache_lru;

    localparam int BW         = 4;
    localparam int LINE_BYTES = BW * 4;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        ResetN       = 1'b0;
    logic        ReadEnable   = 1'b0;
    logic [31:0] ReadAddress  = '0;
    logic        Flush        = 1'b0;
    logic [31:0] MemDataIn    = '0;
    logic        MemDataReady = 1'b0;

    logic [31:0] Instruction;
    logic        Ready;
    logic        Busy;
    logic [31:0] MemReadAddress;
    logic        MemReadRequest;
    logic [31:0] HitCount;
    logic [31:0] MissCount;

    logic [31:0] c_instruction;
    logic        c_ready;
    logic        c_busy;
    logic [31:0] c_mem_addr;
    logic        c_mem_req;
    logic [1:0]  c_hit;
    logic [1:0]  c_miss;

    ucsbece154_icache_lru dut (
        .Clk(clk), .ResetN(ResetN), .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
        .Flush(Flush), .Instruction(Instruction), .Ready(Ready), .Busy(Busy),
        .MemReadAddress(MemReadAddress), .MemReadRequest(MemReadRequest),
        .MemDataIn(MemDataIn), .MemDataReady(MemDataReady),
        .HitCount(HitCount), .MissCount(MissCount)
    );

    ucsbece154_icache_lru #(.CNT_WIDTH(2)) u_cnt (
        .Clk(clk), .ResetN(ResetN), .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
        .Flush(Flush), .Instruction(c_instruction), .Ready(c_ready), .Busy(c_busy),
        .MemReadAddress(c_mem_addr), .MemReadRequest(c_mem_req),
        .MemDataIn(MemDataIn), .MemDataReady(MemDataReady),
        .HitCount(c_hit), .MissCount(c_miss)
    );

    // Scoreboard state
    logic [31:0] exp_q[$];
    int n_checks   = 0;
    int n_pass     = 0;
    int n_fail     = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    function automatic logic [31:0] word_data(input logic [31:0] a);
        return 32'h60 + (a >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: every Ready pulse must match the oldest queued fetch.
    always @(negedge clk) begin
        if (ResetN && Ready) begin
            if (exp_q.size() == 0)
                check("ready_spurious", 32'd1, 32'd0);
            else
                check("instr", Instruction, exp_q.pop_front());
        end
    end

    // Driver tasks: each is entered right after a falling edge and returns at one.
    task automatic do_reset();
        ResetN       = 1'b0;
        ReadEnable   = 1'b0;
        Flush        = 1'b0;
        MemDataReady = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        check("rst_instr", Instruction, 32'd0);
        check("rst_ready", {31'd0, Ready}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_memaddr", MemReadAddress, 32'd0);
        check("rst_memreq", {31'd0, MemReadRequest}, 32'd0);
        check("rst_hits", HitCount, 32'd0);
        check("rst_misses", MissCount, 32'd0);
        ResetN     = 1'b1;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic flush_idle();
        Flush = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        check("flush_idle_busy", {31'd0, Busy}, 32'd0);
        check("flush_idle_ready", {31'd0, Ready}, 32'd0);
    endtask

    // One fetch; on a miss the line is served with `gap` idle cycles before each
    // beat, and Flush is pulsed alongside beat `flush_beat` (-1 for none).
    task automatic access(input logic [31:0] addr, input bit exp_hit, input int gap,
                          input int flush_beat);
        logic [31:0] base;
        int off;
        base = addr & ~32'(LINE_BYTES - 1);
        off  = int'((addr >> 2) % BW);
        ReadEnable  = 1'b1;
        ReadAddress = addr;
        exp_q.push_back(word_data(addr));
        @(negedge clk);
        if (exp_hit) begin
            exp_hits++;
            check("hit_ready", {31'd0, Ready}, 32'd1);
            check("hit_busy", {31'd0, Busy}, 32'd0);
            ReadEnable = 1'b0;
        end else begin
            exp_misses++;
            check("miss_busy", {31'd0, Busy}, 32'd1);
            check("miss_memreq", {31'd0, MemReadRequest}, 32'd1);
            check("miss_memaddr", MemReadAddress, base);
            check("miss_ready", {31'd0, Ready}, 32'd0);
            for (int i = 0; i < BW; i++) begin
                repeat (gap) @(negedge clk);
                MemDataReady = 1'b1;
                MemDataIn    = word_data(base + 32'(4 * i));
                Flush        = (i == flush_beat);
                @(negedge clk);
                MemDataReady = 1'b0;
                Flush        = 1'b0;
                check("beat_ready", {31'd0, Ready}, {31'd0, (i == off)});
                if (i < BW - 1) begin
                    check("fill_busy", {31'd0, Busy}, 32'd1);
                    check("fill_memreq", {31'd0, MemReadRequest}, 32'd1);
                end
            end
            check("done_memreq", {31'd0, MemReadRequest}, 32'd0);
            if (flush_beat >= 0) begin
                check("flush_hold_busy", {31'd0, Busy}, 32'd1);
                @(negedge clk);
                check("flush_done_ready", {31'd0, Ready}, 32'd0);
            end
            check("done_busy", {31'd0, Busy}, 32'd0);
            ReadEnable = 1'b0;
        end
        check("hit_count", HitCount, 32'(exp_hits));
        check("miss_count", MissCount, 32'(exp_misses));
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Basic miss with early restart on word 0, then a hit on word 3
        access(32'h100, 1'b0, 0, -1);
        access(32'h10C, 1'b1, 0, -1);

        // Early restart with spaced beats: Ready after beat 2 while Busy=1
        flush_idle();
        access(32'h108, 1'b0, 3, -1);

        // LRU with default ages
        flush_idle();
        access(32'h000, 1'b0, 0, -1);
        access(32'h080, 1'b0, 0, -1);
        access(32'h100, 1'b0, 0, -1);
        access(32'h180, 1'b0, 0, -1);
        access(32'h004, 1'b1, 0, -1);
        access(32'h200, 1'b0, 1, -1);
        access(32'h000, 1'b1, 0, -1);
        access(32'h08C, 1'b0, 0, -1);

        // Flush pulse during a refill
        access(32'h504, 1'b0, 1, 1);
        access(32'h504, 1'b0, 0, -1);

        // Flush and ReadEnable together on a cached line
        ReadEnable  = 1'b1;
        ReadAddress = 32'h504;
        Flush       = 1'b1;
        @(negedge clk);
        Flush = 1'b0;
        check("fl_re_ready", {31'd0, Ready}, 32'd0);
        check("fl_re_busy", {31'd0, Busy}, 32'd0);
        check("fl_re_hits", HitCount, 32'(exp_hits));
        check("fl_re_misses", MissCount, 32'(exp_misses));
        access(32'h504, 1'b0, 0, -1);

        // Reset on beat 2 of a refill
        ReadEnable  = 1'b1;
        ReadAddress = 32'h30C;
        exp_q.push_back(word_data(32'h30C));
        @(negedge clk);
        check("rst_fill_busy", {31'd0, Busy}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            MemDataReady = 1'b1;
            MemDataIn    = word_data(32'h300 + 32'(4 * i));
            @(negedge clk);
            MemDataReady = 1'b0;
        end
        MemDataReady = 1'b1;
        MemDataIn    = word_data(32'h308);
        ResetN       = 1'b0;
        @(negedge clk);
        MemDataReady = 1'b0;
        ReadEnable   = 1'b0;
        exp_q.delete();
        check("abort_instr", Instruction, 32'd0);
        check("abort_ready", {31'd0, Ready}, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_memaddr", MemReadAddress, 32'd0);
        check("abort_memreq", {31'd0, MemReadRequest}, 32'd0);
        check("abort_hits", HitCount, 32'd0);
        check("abort_misses", MissCount, 32'd0);
        ResetN     = 1'b1;
        exp_hits   = 0;
        exp_misses = 0;
        access(32'h30C, 1'b0, 1, -1);

        // Five back-to-back hits: the 2-bit counters saturate
        for (int k = 0; k < 5; k++)
            access(32'h300 + 32'(4 * (k % BW)), 1'b1, 0, -1);
        check("sat_hits", {30'd0, c_hit}, 32'd3);
        check("sat_misses", {30'd0, c_miss}, 32'd1);

        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
